// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: junction + pedestrian sequencer driving one external timer; night flashing built with TLC_NIGHT_MODE_EN.
// Latency: all outputs registered, phase change one edge after a qualified expiry; no backpressure, timer handshake only.
module traffic_light_ctrl #(
    parameter logic [3:0] T_BASE = 4'd8,
    parameter logic [3:0] T_EXT  = 4'd4,
    parameter logic [3:0] T_YEL  = 4'd3,
    parameter logic [3:0] T_WALK = 4'd6
) (
    input  logic       clk,
    input  logic       g_reset,
    input  logic       oneHzEnable,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       night_mode,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_MAIN_GRN = 3'd1,
        S_MAIN_YEL = 3'd2,
        S_WALK     = 3'd3,
        S_SIDE_GRN = 3'd4,
        S_SIDE_YEL = 3'd5,
        S_FLASH    = 3'd6
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    state_t     state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] tval_q, tval_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_q, walk_d;
    logic       car_pend_q, car_pend_d;
    logic       walk_pend_q, walk_pend_d;
    logic       ext_used_q, ext_used_d;
    logic       exp_ok;
    logic       night_go;

    // The start cycle may still see the previous interval's expiry, so it never counts.
    assign exp_ok = expired & ~start_q;

`ifdef TLC_NIGHT_MODE_EN
    assign night_go = night_mode;
`else
    logic unused_night_inputs;
    assign night_go            = 1'b0;
    assign unused_night_inputs = night_mode ^ oneHzEnable;
`endif

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        tval_d     = tval_q;
        ext_used_d = ext_used_q;
        case (state_q)
            S_INIT: begin
                state_d = S_MAIN_GRN;
                start_d = 1'b1;
                tval_d  = T_BASE;
            end
            S_MAIN_GRN: begin
                if (exp_ok) begin
                    if (night_go) begin
                        state_d = S_FLASH;
                    end else if (car_pend_q || walk_pend_q) begin
                        state_d = S_MAIN_YEL;
                        start_d = 1'b1;
                        tval_d  = T_YEL;
                    end else begin
                        start_d = 1'b1;
                        tval_d  = T_BASE;
                    end
                end
            end
            S_MAIN_YEL: begin
                if (exp_ok) begin
                    start_d = 1'b1;
                    if (walk_pend_q) begin
                        state_d = S_WALK;
                        tval_d  = T_WALK;
                    end else begin
                        state_d    = S_SIDE_GRN;
                        tval_d     = T_BASE;
                        ext_used_d = 1'b0;
                    end
                end
            end
            S_WALK: begin
                if (exp_ok) begin
                    start_d = 1'b1;
                    tval_d  = T_BASE;
                    if (car_pend_q) begin
                        state_d    = S_SIDE_GRN;
                        ext_used_d = 1'b0;
                    end else begin
                        state_d = S_MAIN_GRN;
                    end
                end
            end
            S_SIDE_GRN: begin
                if (exp_ok) begin
                    start_d = 1'b1;
                    if (sensor && !ext_used_q) begin
                        tval_d     = T_EXT;
                        ext_used_d = 1'b1;
                    end else begin
                        state_d = S_SIDE_YEL;
                        tval_d  = T_YEL;
                    end
                end
            end
            S_SIDE_YEL: begin
                if (exp_ok) begin
                    if (night_go) begin
                        state_d = S_FLASH;
                    end else begin
                        state_d = S_MAIN_GRN;
                        start_d = 1'b1;
                        tval_d  = T_BASE;
                    end
                end
            end
`ifdef TLC_NIGHT_MODE_EN
            S_FLASH: begin
                if (!night_mode) begin
                    state_d = S_MAIN_YEL;
                    start_d = 1'b1;
                    tval_d  = T_YEL;
                end
            end
`endif
            default: state_d = S_INIT;
        endcase
    end

    // Clearing is keyed on the next state so that clear beats a same-cycle set.
    always_comb begin
        car_pend_d  = car_pend_q | sensor;
        walk_pend_d = walk_pend_q | walk_request;
        if (state_d == S_SIDE_GRN || state_d == S_SIDE_YEL) begin
            car_pend_d = 1'b0;
        end
        if (state_d == S_WALK) begin
            walk_pend_d = 1'b0;
        end
    end

    always_comb begin
        main_d = L_RED;
        side_d = L_RED;
        walk_d = 1'b0;
        case (state_d)
            S_MAIN_GRN: main_d = L_GRN;
            S_MAIN_YEL: main_d = L_YEL;
            S_WALK:     walk_d = 1'b1;
            S_SIDE_GRN: side_d = L_GRN;
            S_SIDE_YEL: side_d = L_YEL;
`ifdef TLC_NIGHT_MODE_EN
            S_FLASH: begin
                if (state_q != S_FLASH) begin
                    main_d = L_YEL;
                    side_d = L_RED;
                end else if (oneHzEnable) begin
                    main_d = main_q ^ L_YEL;
                    side_d = side_q ^ L_RED;
                end else begin
                    main_d = main_q;
                    side_d = side_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            state_q     <= S_INIT;
            start_q     <= 1'b0;
            tval_q      <= 4'd0;
            main_q      <= L_RED;
            side_q      <= L_RED;
            walk_q      <= 1'b0;
            car_pend_q  <= 1'b0;
            walk_pend_q <= 1'b0;
            ext_used_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            tval_q      <= tval_d;
            main_q      <= main_d;
            side_q      <= side_d;
            walk_q      <= walk_d;
            car_pend_q  <= car_pend_d;
            walk_pend_q <= walk_pend_d;
            ext_used_q  <= ext_used_d;
        end
    end

    assign start_timer = start_q;
    assign timer_value = tval_q;
    assign main_light  = main_q;
    assign side_light  = side_q;
    assign walk        = walk_q;
    assign state       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a behavioural seconds-timer model (one tick per clock).
// Night-mode checks are compiled when TLC_NIGHT_MODE_EN is defined.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       g_reset = 1'b0;
    logic       oneHzEnable = 1'b0;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       night_mode = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [3:0] timer_value;
    logic [2:0] main_light, side_light, state;
    logic       walk;

    logic       expired0;
    logic       start_timer0;
    logic [3:0] timer_value0;
    logic [2:0] main_light0, side_light0, state0;
    logic       walk0;

    int n_checks = 0;
    int n_fail   = 0;
    int safety_viol = 0;

    int   cnt = 0, cnt0 = 0;
    logic tmr_exp = 1'b0, tmr_exp0 = 1'b0;
    logic exp_force = 1'b0;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk(clk), .g_reset(g_reset), .oneHzEnable(oneHzEnable), .sensor(sensor),
        .walk_request(walk_request), .night_mode(night_mode), .expired(expired),
        .start_timer(start_timer), .timer_value(timer_value), .main_light(main_light),
        .side_light(side_light), .walk(walk), .state(state)
    );

    traffic_light_ctrl #(.T_BASE(4'd0), .T_EXT(4'd0), .T_YEL(4'd0), .T_WALK(4'd0)) dut0 (
        .clk(clk), .g_reset(g_reset), .oneHzEnable(oneHzEnable), .sensor(sensor),
        .walk_request(walk_request), .night_mode(night_mode), .expired(expired0),
        .start_timer(start_timer0), .timer_value(timer_value0), .main_light(main_light0),
        .side_light(side_light0), .walk(walk0), .state(state0)
    );

    // Timer model: loads on start, counts down one per clock, holds expired until the next start.
    always @(negedge clk) begin
        if (!g_reset) begin
            cnt = 0; tmr_exp = 1'b0;
        end else if (start_timer) begin
            cnt = int'(timer_value); tmr_exp = (timer_value == 4'd0);
        end else if (!tmr_exp && cnt > 0) begin
            cnt--;
            if (cnt == 0) tmr_exp = 1'b1;
        end
        if (!g_reset) begin
            cnt0 = 0; tmr_exp0 = 1'b0;
        end else if (start_timer0) begin
            cnt0 = int'(timer_value0); tmr_exp0 = (timer_value0 == 4'd0);
        end else if (!tmr_exp0 && cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) tmr_exp0 = 1'b1;
        end
    end
    assign expired  = tmr_exp | exp_force;
    assign expired0 = tmr_exp0;

    // Lamp-safety tally, compared once in test_safety.
    always @(negedge clk) begin
        if (g_reset) begin
            if ((|main_light[1:0]) && (|side_light[1:0])) safety_viol++;
            if (walk && (main_light !== 3'b100 || side_light !== 3'b100)) safety_viol++;
            if ((|main_light0[1:0]) && (|side_light0[1:0])) safety_viol++;
            if (walk0 && (main_light0 !== 3'b100 || side_light0 !== 3'b100)) safety_viol++;
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (start_timer === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 3'd0 || start_timer !== 1'b0 || timer_value !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d start=%b tv=%0d want 0/0/0", state, start_timer, timer_value);
        end
        n_checks++;
        if (main_light !== 3'b100 || side_light !== 3'b100 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lamps: main=%b side=%b walk=%b want 100/100/0", main_light, side_light, walk);
        end
        g_reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (start_timer !== 1'b1 || timer_value !== 4'd8 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL first_start: start=%b tv=%0d state=%0d want 1/8/1", start_timer, timer_value, state);
        end
        n_checks++;
        if (main_light !== 3'b001 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL first_lamps: main=%b side=%b want 001/100", main_light, side_light);
        end
    endtask

    task automatic test_main_idle();
        int n;
`ifndef TLC_NIGHT_MODE_EN
        night_mode  = 1'b1;
        oneHzEnable = 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            wait_start(n);
            n_checks++;
            if (n != 9 || state !== 3'd1 || timer_value !== 4'd8 || main_light !== 3'b001) begin
                n_fail++;
                $display("FAIL idle_restart%0d: gap=%0d state=%0d tv=%0d main=%b want 9/1/8/001",
                         k, n, state, timer_value, main_light);
            end
        end
        night_mode  = 1'b0;
        oneHzEnable = 1'b0;
    endtask

    task automatic test_sensor_pulse();
        int n;
        sensor = 1'b1;
        @(negedge clk);
        sensor = 1'b0;
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd2 || timer_value !== 4'd3 || main_light !== 3'b010 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL sens_main_yel: state=%0d tv=%0d main=%b side=%b want 2/3/010/100",
                     state, timer_value, main_light, side_light);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd4 || timer_value !== 4'd8 || main_light !== 3'b100 || side_light !== 3'b001) begin
            n_fail++;
            $display("FAIL sens_side_grn: state=%0d tv=%0d main=%b side=%b want 4/8/100/001",
                     state, timer_value, main_light, side_light);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd5 || timer_value !== 4'd3 || side_light !== 3'b010) begin
            n_fail++;
            $display("FAIL sens_side_yel: state=%0d tv=%0d side=%b want 5/3/010", state, timer_value, side_light);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd1 || timer_value !== 4'd8) begin
            n_fail++;
            $display("FAIL sens_back_main: state=%0d tv=%0d want 1/8", state, timer_value);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL sens_pend_cleared: state=%0d want 1", state);
        end
    endtask

    task automatic test_extension();
        int n;
        sensor = 1'b1;
        wait_start(n);
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd4 || timer_value !== 4'd8) begin
            n_fail++;
            $display("FAIL ext_side_grn: state=%0d tv=%0d want 4/8", state, timer_value);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd4 || timer_value !== 4'd4) begin
            n_fail++;
            $display("FAIL ext_restart: state=%0d tv=%0d want 4/4", state, timer_value);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd5 || timer_value !== 4'd3) begin
            n_fail++;
            $display("FAIL ext_single: state=%0d tv=%0d want 5/3", state, timer_value);
        end
        sensor = 1'b0;
        wait_start(n);
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd1 || timer_value !== 4'd8) begin
            n_fail++;
            $display("FAIL ext_pend_held_clear: state=%0d tv=%0d want 1/8", state, timer_value);
        end
    endtask

    task automatic test_walk();
        int n;
        sensor       = 1'b1;
        walk_request = 1'b1;
        @(negedge clk);
        sensor       = 1'b0;
        walk_request = 1'b0;
        wait_start(n);
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd3 || timer_value !== 4'd6 || walk !== 1'b1 ||
            main_light !== 3'b100 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL walk_phase: state=%0d tv=%0d walk=%b main=%b side=%b want 3/6/1/100/100",
                     state, timer_value, walk, main_light, side_light);
        end
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd4 || timer_value !== 4'd8 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_to_side: state=%0d tv=%0d walk=%b want 4/8/0", state, timer_value, walk);
        end
        wait_start(n);
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL walk_back_main: state=%0d want 1", state);
        end
    endtask

    task automatic test_back_to_back();
        int n, pulses, dbl;
        logic prev;
        exp_force = 1'b1;
        pulses = 0; dbl = 0; prev = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start_timer) pulses++;
            if (start_timer && prev) dbl++;
            prev = start_timer;
        end
        n_checks++;
        if (pulses != 5 || dbl != 0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL stuck_expired: pulses=%0d doubles=%0d state=%0d want 5/0/1", pulses, dbl, state);
        end
        wait_start(n);
        sensor = 1'b1;
        @(negedge clk);
        sensor = 1'b0;
        wait_start(n);
        n_checks++;
        if (n != 1 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL stuck_main_yel: gap=%0d state=%0d want 1/2", n, state);
        end
        wait_start(n);
        n_checks++;
        if (n != 2 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL stuck_side_grn: gap=%0d state=%0d want 2/4", n, state);
        end
        wait_start(n);
        wait_start(n);
        n_checks++;
        if (n != 2 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL stuck_main_grn: gap=%0d state=%0d want 2/1", n, state);
        end
        exp_force = 1'b0;
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd1 || timer_value !== 4'd8) begin
            n_fail++;
            $display("FAIL stuck_release: state=%0d tv=%0d want 1/8", state, timer_value);
        end
    endtask

`ifdef TLC_NIGHT_MODE_EN
    task automatic test_night();
        int n, starts;
        bit hit;
        night_mode = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (state === 3'd6) hit = 1;
        end
        n_checks++;
        if (!hit || main_light !== 3'b010 || side_light !== 3'b100 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL flash_entry: state=%0d main=%b side=%b walk=%b want 6/010/100/0",
                     state, main_light, side_light, walk);
        end
        oneHzEnable = 1'b1;
        @(negedge clk);
        oneHzEnable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (main_light !== 3'b000 || side_light !== 3'b000) begin
            n_fail++;
            $display("FAIL flash_toggle1: main=%b side=%b want 000/000", main_light, side_light);
        end
        oneHzEnable = 1'b1;
        @(negedge clk);
        oneHzEnable = 1'b0;
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (start_timer) starts++;
        end
        n_checks++;
        if (main_light !== 3'b010 || side_light !== 3'b100 || starts != 0 || state !== 3'd6) begin
            n_fail++;
            $display("FAIL flash_toggle2: main=%b side=%b starts=%0d state=%0d want 010/100/0/6",
                     main_light, side_light, starts, state);
        end
        night_mode = 1'b0;
        wait_start(n);
        n_checks++;
        if (n == 0 || state !== 3'd2 || timer_value !== 4'd3) begin
            n_fail++;
            $display("FAIL flash_exit: state=%0d tv=%0d want 2/3", state, timer_value);
        end
        night_mode = 1'b1;
        hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge clk);
            if (state === 3'd6) hit = 1;
        end
        g_reset = 1'b0;
        #1;
        n_checks++;
        if (!hit || state !== 3'd0 || main_light !== 3'b100 || side_light !== 3'b100 ||
            start_timer !== 1'b0 || timer_value !== 4'd0) begin
            n_fail++;
            $display("FAIL flash_reset: reached=%0d state=%0d main=%b side=%b start=%b tv=%0d want 1/0/100/100/0/0",
                     hit, state, main_light, side_light, start_timer, timer_value);
        end
        night_mode = 1'b0;
        @(negedge clk);
        g_reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || start_timer !== 1'b1 || timer_value !== 4'd8) begin
            n_fail++;
            $display("FAIL flash_rerelease: state=%0d start=%b tv=%0d want 1/1/8", state, start_timer, timer_value);
        end
    endtask
`endif

    task automatic test_zero_durations();
        logic [7:0] mask;
        int starts0;
        mask = 8'd0; starts0 = 0;
        sensor       = 1'b1;
        walk_request = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mask[state0] = 1'b1;
            if (start_timer0) starts0++;
        end
        sensor       = 1'b0;
        walk_request = 1'b0;
        n_checks++;
        if (mask !== 8'b0011_1110 || starts0 < 15) begin
            n_fail++;
            $display("FAIL zero_duration: visited=%b starts=%0d want 00111110/>=15", mask, starts0);
        end
    endtask

    task automatic test_safety();
        n_checks++;
        if (safety_viol != 0) begin
            n_fail++;
            $display("FAIL lamp_safety: violations=%0d want 0", safety_viol);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_main_idle();
        test_sensor_pulse();
        test_extension();
        test_walk();
        test_back_to_back();
`ifdef TLC_NIGHT_MODE_EN
        test_night();
`endif
        test_zero_durations();
        test_safety();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Sequences a main-road / side-road junction with a pedestrian crossing.
- Drives one external seconds timer: each phase loads a duration, pulses a start, then waits for the timer's expired flag.
- Latches car-sensor and walk-button requests, decides the next phase at each expiry and drives the lamp outputs.

Parameters:
T_BASE, 4'd8, green duration for main and side phases (seconds)
T_EXT, 4'd4, one-time side-green extension while sensor still occupied
T_YEL, 4'd3, yellow duration
T_WALK, 4'd6, all-red pedestrian walk duration

Ports:
clk  input  1  system clock
g_reset  input  1  asynchronous active-low reset
oneHzEnable  input  1  one-cycle 1 Hz tick (used only by optional feature)
sensor  input  1  side-road car present (level)
walk_request  input  1  pedestrian button (level or pulse)
night_mode  input  1  night flashing request (used only by optional feature)
expired  input  1  timer expiry flag; held high until the next start
start_timer  output  1  one-cycle registered pulse; restarts the timer
timer_value  output  4  duration for the current interval; stable while interval runs
main_light  output  3  {red,yellow,green}, one-hot
side_light  output  3  {red,yellow,green}, one-hot
walk  output  1  walk lamp
state  output  3  current FSM state (debug)

Behaviour:
- All state registers are reset asynchronously on g_reset low.
- Reset values: state=INIT, start_timer=0, timer_value=0, main_light=3'b100, side_light=3'b100, walk=0, car_pend=0, walk_pend=0, ext_used=0.
- Lamps are a registered decode of state. Encodings: INIT=0, MAIN_GRN=1, MAIN_YEL=2, WALK=3, SIDE_GRN=4, SIDE_YEL=5, FLASH=6.
- Phase entry always does three things in the same edge: set timer_value, assert start_timer for exactly 1 cycle, update state.
- Expiry qualification: expired is evaluated only in cycles where start_timer==0. In the cycle start_timer is high, expired may still carry the previous interval's value and is ignored.
- INIT: first edge after reset release -> MAIN_GRN with T_BASE.
- MAIN_GRN (main G, side R):
  - On expired, if car_pend|walk_pend -> MAIN_YEL (T_YEL).
  - Otherwise stay and restart T_BASE.
- MAIN_YEL (main Y, side R): on expired -> WALK (T_WALK) if walk_pend, else SIDE_GRN (T_BASE).
- WALK (both R, walk=1): on expired -> SIDE_GRN (T_BASE) if car_pend, else MAIN_GRN (T_BASE).
- SIDE_GRN (main R, side G):
  - On expired, if sensor && !ext_used -> restart with T_EXT and set ext_used.
  - Otherwise -> SIDE_YEL (T_YEL).
- SIDE_YEL (main R, side Y): on expired -> MAIN_GRN (T_BASE).
- Request latches:
  - car_pend: set when sensor=1. Cleared on entry to SIDE_GRN. Held clear while in SIDE_GRN/SIDE_YEL.
  - walk_pend: set when walk_request=1. Cleared on entry to WALK. Held clear while in WALK.
  - Set and clear in the same cycle: clear wins.
- ext_used: cleared on every entry to SIDE_GRN.
- Duration 0 is legal: the timer expires on the first cycle after it samples start. The FSM must advance without deadlock.
- Reset mid-phase: immediate return to reset values. Any timer interval in progress is abandoned; the next start_timer restarts it.
- Lamp safety: main and side are never both non-red in any cycle. walk=1 only when both are red.

Optional Feature:
- Macro: TLC_NIGHT_MODE_EN.
- Defined:
  - At any qualified expiry in MAIN_GRN or SIDE_YEL with night_mode=1 -> FLASH.
  - In FLASH, main yellow and side red each toggle on every oneHzEnable. Walk=0, timer not started, requests still latched.
  - On night_mode=0 -> MAIN_YEL (T_YEL), then normal sequencing.
- Not defined: night_mode and oneHzEnable are ignored, FLASH is unreachable, no extra logic.

Test Plan:
- Reset low 3 cycles, release; no requests, timer model returns expired 8 ticks after start -> start_timer pulse with timer_value=8 one edge after release; MAIN_GRN restarts T_BASE indefinitely; main_light=001, side_light=100.
- Pulse sensor once during MAIN_GRN -> at expiry MAIN_YEL (value 3), then SIDE_GRN (value 8), then SIDE_YEL, then MAIN_GRN; car_pend=0 after SIDE_GRN entry.
- Hold sensor high through SIDE_GRN -> exactly one restart with timer_value=4, then SIDE_YEL; no second extension.
- walk_request and sensor both set in MAIN_GRN -> MAIN_YEL, then WALK (walk=1, both red, value 6), then SIDE_GRN.
- Hold expired stuck high across a phase change -> no double advance: the start_timer cycle ignores expired, exactly one transition per interval. Parameters set to 0 -> sequence still cycles.
- With TLC_NIGHT_MODE_EN: night_mode=1 in MAIN_GRN -> FLASH at expiry, main yellow toggles each oneHzEnable; night_mode=0 -> MAIN_YEL with timer_value=3. Async reset mid-FLASH -> INIT values immediately.
